// File: rtl/sram_1p_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_1p_arbiter_pkg: shared geometry defaults and FSM state encoding.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sram_1p_arbiter_pkg;

    localparam int DEPTH_DEFAULT = 816;
    localparam int AW_DEFAULT    = 10;
    localparam int DW_DEFAULT    = 32;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sram_1p_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2: two-way round-robin grant; last-grant register favours req0 first.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2
    import sram_1p_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // last_q = 1 means requester 1 was granted most recently
    logic last_q;
    logic last_d;

    always_comb begin
        gnt0   = en & req0 & (~req1 | last_q);
        gnt1   = en & req1 & (~req0 | ~last_q);
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_1p_arbiter.sv
// ----------------------------------------------------------------------------
// sram_1p_arbiter: two requesters sharing one single-port SRAM, with power-up clear.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_1p_arbiter
    import sram_1p_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp0_err,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          rsp1_err,
    output logic          init_done,
    output logic          sram_ceb,
    output logic          sram_web,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          init_done_q, init_done_d;
    logic          iss_valid_q, iss_valid_d;
    logic          iss_id_q, iss_id_d;
    logic          iss_we_q, iss_we_d;
    logic          iss_err_q, iss_err_d;
    logic          ceb_q, ceb_d;
    logic          web_q, web_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic          rsp_rd_q, rsp_rd_d;
    logic          rsp_err_q, rsp_err_d;

    logic          w_gnt0, w_gnt1, w_acc;
    logic          w_cmd_we, w_cmd_err;
    logic [AW-1:0] w_cmd_addr;
    logic [DW-1:0] w_cmd_wdata;

    // Reset also blocks grants so nothing is accepted during the reset cycle
    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RSTN),
        .en    ((state_q == ST_RUN) & RSTN),
        .req0  (req0_valid),
        .req1  (req1_valid),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign w_acc       = w_gnt0 | w_gnt1;
    assign w_cmd_we    = w_gnt1 ? req1_we    : req0_we;
    assign w_cmd_addr  = w_gnt1 ? req1_addr  : req0_addr;
    assign w_cmd_wdata = w_gnt1 ? req1_wdata : req0_wdata;
    assign w_cmd_err   = ({1'b0, w_cmd_addr} >= LAST_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        iss_valid_d = 1'b0;
        iss_id_d    = 1'b0;
        iss_we_d    = 1'b0;
        iss_err_d   = 1'b0;
        ceb_d       = 1'b1;
        web_d       = 1'b1;
        a_d         = '0;
        d_d         = '0;
        rsp_valid_d = iss_valid_q;
        rsp_id_d    = iss_id_q;
        rsp_rd_d    = iss_valid_q & ~iss_we_q & ~iss_err_q;
        rsp_err_d   = iss_valid_q & iss_err_q;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    ceb_d = 1'b0;
                    web_d = 1'b0;
                    a_d   = cnt_q[AW-1:0];
                    cnt_d = cnt_q + (AW+1)'(1);
                end
            end
            ST_RUN: begin
                if (w_acc) begin
                    iss_valid_d = 1'b1;
                    iss_id_d    = w_gnt1;
                    iss_we_d    = w_cmd_we;
                    iss_err_d   = w_cmd_err;
                    if (!w_cmd_err) begin
                        ceb_d = 1'b0;
                        web_d = ~w_cmd_we;
                        a_d   = w_cmd_addr;
                        d_d   = w_cmd_we ? w_cmd_wdata : '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_we_q    <= 1'b0;
            iss_err_q   <= 1'b0;
            ceb_q       <= 1'b1;
            web_q       <= 1'b1;
            a_q         <= '0;
            d_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rd_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            iss_we_q    <= iss_we_d;
            iss_err_q   <= iss_err_d;
            ceb_q       <= ceb_d;
            web_q       <= web_d;
            a_q         <= a_d;
            d_q         <= d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign init_done = init_done_q;
    assign sram_ceb  = ceb_q;
    assign sram_web  = web_q;
    assign sram_a    = a_q;
    assign sram_d    = d_q;

    // SRAM read data arrives during the response cycle, so it is muxed through unregistered
    assign rsp0_valid = rsp_valid_q & ~rsp_id_q;
    assign rsp1_valid = rsp_valid_q & rsp_id_q;
    assign rsp0_err   = rsp0_valid & rsp_err_q;
    assign rsp1_err   = rsp1_valid & rsp_err_q;
    assign rsp0_rdata = (rsp0_valid & rsp_rd_q) ? sram_q : '0;
    assign rsp1_rdata = (rsp1_valid & rsp_rd_q) ? sram_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_sram_1p_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_1p_arbiter: directed self-checking bench with a behavioural SRAM model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_1p_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          init_done, sram_ceb, sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    sram_1p_arbiter dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .init_done  (init_done),
        .sram_ceb   (sram_ceb),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    // Single-port SRAM: writes whenever web=0, registered read data
    always @(posedge CLK) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_init();
        int n = 0, writes = 0, bad = 0, rdy_bad = 0, rsp_bad = 0, nz = 0;
        logic [AW-1:0] exp_a = '0;
        while (n < 2000) begin
            @(negedge CLK);
            n++;
            if (init_done) break;
            if (req0_ready || req1_ready) rdy_bad++;
            if (rsp0_valid || rsp1_valid) rsp_bad++;
            if (!sram_ceb) begin
                if (sram_web || sram_a !== exp_a || sram_d !== '0) bad++;
                writes++;
                exp_a++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 816; k++) if (mem[k] !== '0) nz++;
        check("init_done", init_done, 1);
        check("init_writes", writes, 816);
        check("init_seq", bad, 0);
        check("init_ready", rdy_bad, 0);
        check("init_rsp", rsp_bad, 0);
        check("init_mem_clear", nz, 0);
        check("init_idle_ceb", sram_ceb, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < (1 << AW); k++) mem[k] = 32'hA5A5A5A5;
        RSTN = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        repeat (3) @(negedge CLK);

        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_err", rsp0_err, 0);
        check("rst_rsp1_rdata", rsp1_rdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_ceb", sram_ceb, 1);
        check("rst_web", sram_web, 1);
        check("rst_a", sram_a, 0);
        check("rst_d", sram_d, 0);

        // Requests held valid throughout the clear must never be accepted
        req0_valid = 1; req0_we = 0; req0_addr = 10'd3;
        req1_valid = 1; req1_we = 1; req1_addr = 10'd4; req1_wdata = 32'h1234;
        RSTN = 1'b1;
        wait_init();

        // Read 5 on req0
        req0_valid = 1; req0_we = 0; req0_addr = 10'd5;
        #1;
        check("rd5_ready0", req0_ready, 1);
        check("rd5_ready1", req1_ready, 0);
        @(negedge CLK);
        req0_valid = 0;
        check("rd5_ceb", sram_ceb, 0);
        check("rd5_web", sram_web, 1);
        check("rd5_a", sram_a, 5);
        @(negedge CLK);
        check("rd5_rsp0_valid", rsp0_valid, 1);
        check("rd5_rsp0_rdata", rsp0_rdata, 0);
        check("rd5_rsp0_err", rsp0_err, 0);
        check("rd5_rsp1_valid", rsp1_valid, 0);
        @(negedge CLK);
        check("rd5_pulse_end", rsp0_valid, 0);

        // Write then read-back of address 10
        req0_valid = 1; req0_we = 1; req0_addr = 10'd10; req0_wdata = 32'hDEADBEEF;
        @(negedge CLK);
        check("wr10_ceb", sram_ceb, 0);
        check("wr10_web", sram_web, 0);
        check("wr10_a", sram_a, 10);
        check("wr10_d", sram_d, 32'hDEADBEEF);
        req0_we = 0;
        @(negedge CLK);
        req0_valid = 0;
        check("wr10_ack_valid", rsp0_valid, 1);
        check("wr10_ack_err", rsp0_err, 0);
        check("wr10_ack_rdata", rsp0_rdata, 0);
        @(negedge CLK);
        check("raw10_valid", rsp0_valid, 1);
        check("raw10_rdata", rsp0_rdata, 32'hDEADBEEF);
        @(negedge CLK);
        check("idle_rsp0_valid", rsp0_valid, 0);
        check("idle_rsp0_rdata", rsp0_rdata, 0);

        // Out-of-range reads on req1
        req1_valid = 1; req1_we = 0; req1_addr = 10'd816;
        #1;
        check("oor_ready1", req1_ready, 1);
        @(negedge CLK);
        check("oor816_ceb", sram_ceb, 1);
        check("oor816_web", sram_web, 1);
        req1_addr = 10'd1023;
        @(negedge CLK);
        req1_valid = 0;
        check("oor1023_ceb", sram_ceb, 1);
        check("oor816_valid", rsp1_valid, 1);
        check("oor816_err", rsp1_err, 1);
        check("oor816_rdata", rsp1_rdata, 0);
        check("oor816_rsp0", rsp0_valid, 0);
        @(negedge CLK);
        check("oor1023_valid", rsp1_valid, 1);
        check("oor1023_err", rsp1_err, 1);
        check("oor1023_rdata", rsp1_rdata, 0);
        @(negedge CLK);
        check("oor_pulse_end", rsp1_valid, 0);
        check("oor_err_idle", rsp1_err, 0);

        // req1 writes 20 so the tie test starts with req1 as last grant
        req1_valid = 1; req1_we = 1; req1_addr = 10'd20; req1_wdata = 32'hCAFEF00D;
        @(negedge CLK);
        req1_valid = 0; req1_we = 0;
        @(negedge CLK);
        check("wr20_ack", rsp1_valid, 1);
        @(negedge CLK);

        // Both requesters valid for 6 cycles: grants alternate 0,1,0,1,0,1
        req0_we = 0; req0_addr = 10'd10;
        req1_we = 0; req1_addr = 10'd20;
        for (int i = 0; i < 8; i++) begin
            logic e0;
            req0_valid = (i < 6);
            req1_valid = (i < 6);
            #1;
            check($sformatf("tie_rdy0_%0d", i), req0_ready, (i < 6) && (i % 2 == 0));
            check($sformatf("tie_rdy1_%0d", i), req1_ready, (i < 6) && (i % 2 == 1));
            if (i >= 2) begin
                e0 = ((i - 2) % 2 == 0);
                check($sformatf("tie_rsp0_%0d", i), rsp0_valid, e0);
                check($sformatf("tie_rsp1_%0d", i), rsp1_valid, !e0);
                check($sformatf("tie_rd0_%0d", i), rsp0_rdata, e0 ? 32'hDEADBEEF : 32'h0);
                check($sformatf("tie_rd1_%0d", i), rsp1_rdata, e0 ? 32'h0 : 32'hCAFEF00D);
            end
            @(negedge CLK);
        end
        check("tie_drain", rsp0_valid | rsp1_valid, 0);

        // Reset with a read in flight and another pending
        req0_valid = 1; req0_we = 0; req0_addr = 10'd20;
        #1;
        check("rstf_ready0", req0_ready, 1);
        @(negedge CLK);
        req0_valid = 0;
        req1_valid = 1; req1_we = 0; req1_addr = 10'd20;
        RSTN = 1'b0;
        #1;
        check("rstf_issue_ceb", sram_ceb, 0);
        check("rstf_issue_a", sram_a, 20);
        check("rstf_ready1", req1_ready, 0);
        @(negedge CLK);
        check("rstf_rsp0", rsp0_valid, 0);
        check("rstf_rsp1", rsp1_valid, 0);
        check("rstf_init_done", init_done, 0);
        check("rstf_ceb", sram_ceb, 1);
        check("rstf_ready1_init", req1_ready, 0);
        RSTN = 1'b1;
        wait_init();

        // Address 10 held DEADBEEF before the restart; the clear must have wiped it
        req0_valid = 1; req0_we = 0; req0_addr = 10'd10;
        @(negedge CLK);
        req0_valid = 0;
        @(negedge CLK);
        check("post_rst_valid", rsp0_valid, 1);
        check("post_rst_rdata", rsp0_rdata, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
